// File: rtl/mode1_max_acc_pkg.sv
// mode1_max_acc_pkg: shared widths, fp16 field layout and FSM encoding for the max-reduction front end.
package mode1_max_acc_pkg;
  localparam int DATAWIDTH = 16;
  localparam int EXPONENT  = 5;
  localparam int MANTISSA  = 10;
  localparam int CNT_WIDTH = 8;
  typedef logic [DATAWIDTH-1:0] fp_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/mode1_max_acc_if.sv
// mode1_max_acc_if: beat input stream plus registered row-maximum output handshake.
interface mode1_max_acc_if;
  import mode1_max_acc_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_last;
  fp_t  a_inp0;
  fp_t  a_inp1;
  fp_t  a_inp2;
  fp_t  a_inp3;
  fp_t  max_out;
  logic max_valid;
  logic max_ready;
  cnt_t beat_cnt;
  modport master (
    output in_valid, in_last, a_inp0, a_inp1, a_inp2, a_inp3, max_ready,
    input  in_ready, max_out, max_valid, beat_cnt
  );
  modport slave (
    input  in_valid, in_last, a_inp0, a_inp1, a_inp2, a_inp3, max_ready,
    output in_ready, max_out, max_valid, beat_cnt
  );
endinterface

// File: rtl/mode1_max_acc_fp_max2.sv
// fp_max2: combinational fp16 max by sign/magnitude bit rule; ties (incl. +0 vs -0 with a=+0) return a.
module fp_max2
  import mode1_max_acc_pkg::*;
(
  input  fp_t a,
  input  fp_t b,
  output fp_t z
);
  logic sa, sb;
  logic [EXPONENT+MANTISSA-1:0] ma, mb;
  assign sa = a[DATAWIDTH-1];
  assign sb = b[DATAWIDTH-1];
  assign ma = a[EXPONENT+MANTISSA-1:0];
  assign mb = b[EXPONENT+MANTISSA-1:0];
  always_comb z = (sa != sb) ? (sa ? b : a) : sa ? ((ma <= mb) ? a : b) : ((ma >= mb) ? a : b);
endmodule

// File: rtl/mode1_max_acc.sv
// mode1_max_acc: two-stage streaming row-max of 4-wide fp16 beats, held until the consumer takes it.
module mode1_max_acc
  import mode1_max_acc_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mode1_max_acc_if.slave bus
);
  state_e state_q;
  cnt_t   beat_cnt_q;
  fp_t    max_out_q, m1_q, acc_q;
  logic   max_valid_q, s1_valid_q, s1_last_q, first_q;
  fp_t    m01, m23, m1_d, acc_in, acc_d;
  logic   in_ready, accept, row_done;
  fp_max2 u_max01 (.a(bus.a_inp0), .b(bus.a_inp1), .z(m01));
  fp_max2 u_max23 (.a(bus.a_inp2), .b(bus.a_inp3), .z(m23));
  fp_max2 u_max1  (.a(m01), .b(m23), .z(m1_d));
  // the first beat of a row compares m1 with itself, so one comparator covers load and accumulate
  assign acc_in = first_q ? m1_q : acc_q;
  fp_max2 u_acc (.a(acc_in), .b(m1_q), .z(acc_d));
  assign in_ready = ~reset & (state_q == IDLE || state_q == ACCUM);
  assign accept   = bus.in_valid & in_ready;
  assign row_done = s1_valid_q & s1_last_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      max_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          beat_cnt_q <= cnt_t'(1);
          state_q    <= bus.in_last ? FLUSH : ACCUM;
        end
        ACCUM: if (accept) begin
          beat_cnt_q <= &beat_cnt_q ? beat_cnt_q : beat_cnt_q + cnt_t'(1);
          state_q    <= bus.in_last ? FLUSH : ACCUM;
        end
        FLUSH: if (row_done) begin
          state_q     <= DONE;
          max_valid_q <= 1'b1;
        end
        DONE: if (bus.max_ready) begin
          state_q     <= IDLE;
          max_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      m1_q       <= '0;
      acc_q      <= '0;
      first_q    <= 1'b1;
      max_out_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        m1_q      <= m1_d;
        s1_last_q <= bus.in_last;
      end
      if (s1_valid_q) begin
        acc_q   <= acc_d;
        first_q <= s1_last_q;
      end
      if (row_done) max_out_q <= acc_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.max_out   = max_out_q;
  assign bus.max_valid = max_valid_q;
  assign bus.beat_cnt  = beat_cnt_q;
endmodule
